// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-register busy
// scoreboard. NREAD combinational read ports, one synchronous write port
// (which also retires a pending register) and one allocate port (which marks a
// destination register pending). Register 0 reads as zero and is never pending.
//
// Optional feature macro: REGFILE_SB_BYPASS_EN
//   defined   -> a same-cycle write is forwarded to matching read ports
//   undefined -> reads see stored state only; a write is visible after the edge
//
// Transfer semantics: there is no valid/ready handshake. A write (we3) and an
// allocate (alloc_en) are each accepted on the rising edge where they are
// presented; nothing ever stalls, so the producer needs no back-pressure path.
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       rdy,
    input  logic                   we3,
    input  logic [AW-1:0]          wa3,
    input  logic [WIDTH-1:0]       wd3,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    output logic [AW:0]            busy_cnt,
    output logic                   alloc_err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    // Effective events: anything aimed at register 0 is dropped here.
    logic wr_en;
    logic set_en;
    logic same_addr;
    logic cnt_inc;
    logic cnt_dec;

    // Qualify write/allocate and work out how the pending count moves.
    always_comb begin
        wr_en     = we3 && (wa3 != '0);
        set_en    = alloc_en && (alloc_addr != '0);
        same_addr = (wa3 == alloc_addr);
        // Count rises only when a register goes idle -> pending.
        cnt_inc   = set_en && !busy[alloc_addr];
        // Count falls only when a pending register is retired and not
        // immediately re-allocated by a new producer on the same edge.
        cnt_dec   = wr_en && busy[wa3] && !(set_en && same_addr);
    end

    // Data storage: cleared on reset, written by the writeback port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wa3] <= wd3;
        end
    end

    // Busy vector: write clears, allocate sets; allocate is last so it wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[wa3] <= 1'b0;
            end
            if (set_en) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    // Pending count tracks popcount(busy) incrementally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

    // Sticky error: allocating a register that stays pending (not retired
    // by a same-edge write) means two producers claimed it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_err <= 1'b0;
        end else if (set_en && busy[alloc_addr] && !(wr_en && same_addr)) begin
            alloc_err <= 1'b1;
        end
    end

    // Combinational read ports, with optional same-cycle write forwarding.
    always_comb begin
        rd  = '0;
        rdy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (ra[i*AW +: AW] == '0) begin
                rd[i*WIDTH +: WIDTH] = '0;
                rdy[i]               = 1'b1;
            end else begin
                rd[i*WIDTH +: WIDTH] = mem[ra[i*AW +: AW]];
                rdy[i]               = !busy[ra[i*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
                // Forwarding is suppressed during reset so reads show zeros.
                if (reset_n && we3 && (wa3 == ra[i*AW +: AW])) begin
                    rd[i*WIDTH +: WIDTH] = wd3;
                    rdy[i]               = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb (default parameters: 32 x 32, two read ports).
// A behavioural model (plain arrays, sequential update rules, popcount) is
// compared against every output on each falling edge; directed steps pin the
// model with literal expectations, then randomized traffic runs.
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       rdy;
    logic                   we3;
    logic [AW-1:0]          wa3;
    logic [WIDTH-1:0]       wd3;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;
    logic [AW:0]            busy_cnt;
    logic                   alloc_err;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ra        (ra),
        .rd        (rd),
        .rdy       (rdy),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .busy_cnt  (busy_cnt),
        .alloc_err (alloc_err)
    );

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] mem_m [DEPTH];
    bit               busy_m [DEPTH];
    bit               err_m;
    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
        err_m = 1'b0;
    endtask

    always @(negedge reset_n) model_reset();

    // Apply the edge in program order: write retires, then allocate claims.
    always @(posedge clk) begin
        if (reset_n) begin
            if (we3 && wa3 != 0) begin
                mem_m[wa3]  = wd3;
                busy_m[wa3] = 1'b0;
            end
            if (alloc_en && alloc_addr != 0) begin
                if (busy_m[alloc_addr]) err_m = 1'b1;
                busy_m[alloc_addr] = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(busy_m[i]);
        return n;
    endfunction

    task automatic compare_all();
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] exp_d;
        bit               exp_r;
        for (int i = 0; i < NREAD; i++) begin
            a = ra[i*AW +: AW];
            if (a == 0) begin
                exp_d = '0; exp_r = 1'b1;
            end else begin
                exp_d = mem_m[a]; exp_r = !busy_m[a];
`ifdef REGFILE_SB_BYPASS_EN
                if (we3 && wa3 == a) begin
                    exp_d = wd3; exp_r = 1'b1;
                end
`endif
            end
            chk($sformatf("rd%0d", i), 64'(rd[i*WIDTH +: WIDTH]), 64'(exp_d));
            chk($sformatf("rdy%0d", i), 64'(rdy[i]), 64'(exp_r));
        end
        chk("busy_cnt", 64'(busy_cnt), 64'(model_count()));
        chk("alloc_err", 64'(alloc_err), 64'(err_m));
    endtask

    always @(negedge clk) begin
        if (chk_en && reset_n) compare_all();
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit we, input int wa, input logic [WIDTH-1:0] wd,
                         input bit ae, input int aa, input int r0, input int r1);
        we3        = we;
        wa3        = AW'(wa);
        wd3        = wd;
        alloc_en   = ae;
        alloc_addr = AW'(aa);
        ra         = {AW'(r1), AW'(r0)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 3);
        #3;
        // Reset held: zeros and all-ready regardless of clock.
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_rdy", 64'(rdy), 64'd3);
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_err", 64'(alloc_err), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("post_rst_rd", 64'(rd), 64'd0);
        chk("post_rst_rdy", 64'(rdy), 64'd3);

        // Register 0 protection.
        drive(1, 0, 32'h1, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_rd", 64'(rd[WIDTH-1:0]), 64'd0);
        chk("r0_rdy", 64'(rdy[0]), 64'd1);
        chk("r0_cnt", 64'(busy_cnt), 64'd0);

        // Write then read.
        drive(1, 3, 32'h3, 0, 0, 3, 3);
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("wr_pre_edge", 64'(rd[WIDTH-1:0]), 64'h3);
`else
        chk("wr_pre_edge", 64'(rd[WIDTH-1:0]), 64'h0);
`endif
        tick();
        drive(0, 3, 32'hdead, 0, 0, 3, 3);
        #1;
        chk("wr_post_edge", 64'(rd[WIDTH-1:0]), 64'h3);
        tick();
        chk("wr_hold", 64'(rd[2*WIDTH-1:WIDTH]), 64'h3);

        // Scoreboard: allocate r5 then write it back.
        drive(0, 0, 0, 1, 5, 5, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 0);
        #1;
        chk("alloc_rdy", 64'(rdy[0]), 64'd0);
        chk("alloc_cnt", 64'(busy_cnt), 64'd1);
        drive(1, 5, 32'h7, 0, 0, 5, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 0);
        #1;
        chk("wb_rdy", 64'(rdy[0]), 64'd1);
        chk("wb_rd", 64'(rd[WIDTH-1:0]), 64'h7);
        chk("wb_cnt", 64'(busy_cnt), 64'd0);

        // Simultaneous events.
        drive(0, 0, 0, 1, 2, 2, 1);
        tick();
        drive(1, 2, 32'h9, 1, 1, 2, 1);
        tick();
        drive(0, 0, 0, 0, 0, 2, 1);
        #1;
        chk("setclr_cnt", 64'(busy_cnt), 64'd1);
        chk("setclr_rdy", 64'(rdy), 64'b01);
        drive(1, 1, 32'h11, 1, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("same_rd", 64'(rd[WIDTH-1:0]), 64'h11);
        chk("same_rdy", 64'(rdy[0]), 64'd0);
        chk("same_cnt", 64'(busy_cnt), 64'd1);
        chk("same_err", 64'(alloc_err), 64'd0);
        drive(0, 0, 0, 1, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("dup_err", 64'(alloc_err), 64'd1);
        chk("dup_cnt", 64'(busy_cnt), 64'd1);
        tick();
        chk("err_sticky", 64'(alloc_err), 64'd1);

        // Async reset mid-operation with r1..r3 busy.
        drive(0, 0, 0, 1, 2, 1, 3);
        tick();
        drive(0, 0, 0, 1, 3, 1, 3);
        tick();
        drive(0, 0, 0, 0, 0, 1, 3);
        #1;
        chk("pre_rst_cnt", 64'(busy_cnt), 64'd3);
        chk("pre_rst_rdy", 64'(rdy), 64'b00);
        reset_n = 1'b0;
        #1;
        chk("async_cnt", 64'(busy_cnt), 64'd0);
        chk("async_rd", 64'(rd), 64'd0);
        chk("async_rdy", 64'(rdy), 64'b11);
        chk("async_err", 64'(alloc_err), 64'd0);
        #1 reset_n = 1'b1;

        // Randomized traffic; small address range forces collisions.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 31)));
            if ($urandom_range(0, 199) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        tick();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
